// File: rtl/mtm_pingpong_unit.sv
// mtm_pingpong_unit: streaming NUM_PE x NUM_PE transpose engine with two ping-pong banks.
// One bank fills from the producer while the other drains, transposed or straight, to the consumer.
module mtm_pingpong_unit #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_PE     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_val,
    output logic                  in_rdy,
    input  logic [DATA_WIDTH-1:0] input_row [0:NUM_PE-1],
    input  logic                  transpose_en,
    output logic                  out_val,
    input  logic                  out_rdy,
    output logic [DATA_WIDTH-1:0] output_row [0:NUM_PE-1],
    output logic                  out_last,
    output logic                  busy
);
    localparam int ROW_W = $clog2(NUM_PE);
    localparam logic [ROW_W-1:0] LAST = ROW_W'(NUM_PE - 1);

    logic [DATA_WIDTH-1:0] r_bank [0:1][0:NUM_PE-1][0:NUM_PE-1];
    logic [1:0]            r_full;
    logic [1:0]            r_mode;
    logic                  r_wsel;
    logic                  r_rsel;
    logic [ROW_W-1:0]      r_wrow;
    logic [ROW_W-1:0]      r_rrow;
    logic                  w_wr;
    logic                  w_ld;

    assign in_rdy = !r_full[r_wsel];
    assign w_wr   = in_val && in_rdy;
    assign w_ld   = r_full[r_rsel] && (!out_val || out_rdy);
    assign busy   = |r_full || (r_wrow != '0) || out_val;

    // Bank contents and per-bank mode are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            for (int i = 0; i < NUM_PE; i++)
                r_bank[r_wsel][r_wrow][ROW_W'(i)] <= input_row[i];
            if (r_wrow == '0)
                r_mode[r_wsel] <= transpose_en;
        end
    end

    // Writer only touches a non-full bank and reader only a full one, so the two
    // r_full updates below never target the same bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_full   <= '0;
            r_wsel   <= 1'b0;
            r_rsel   <= 1'b0;
            r_wrow   <= '0;
            r_rrow   <= '0;
            out_val  <= 1'b0;
            out_last <= 1'b0;
            for (int i = 0; i < NUM_PE; i++)
                output_row[i] <= '0;
        end else begin
            if (w_wr) begin
                if (r_wrow == LAST) begin
                    r_full[r_wsel] <= 1'b1;
                    r_wsel         <= !r_wsel;
                end
                r_wrow <= r_wrow + 1'b1;
            end
            if (w_ld) begin
                for (int i = 0; i < NUM_PE; i++)
                    output_row[i] <= r_mode[r_rsel] ? r_bank[r_rsel][ROW_W'(i)][r_rrow]
                                                    : r_bank[r_rsel][r_rrow][ROW_W'(i)];
                out_last <= (r_rrow == LAST);
                if (r_rrow == LAST) begin
                    r_full[r_rsel] <= 1'b0;
                    r_rsel         <= !r_rsel;
                end
                r_rrow <= r_rrow + 1'b1;
            end
            out_val <= w_ld || (out_val && !out_rdy);
        end
    end
endmodule

// File: tb/tb_mtm_pingpong_unit.sv
// tb_mtm_pingpong_unit: directed and randomised stimulus against a row-level scoreboard
// built from the producer side, one handshake sample per cycle just after each edge.
module tb_mtm_pingpong_unit;
    localparam int DW = 64;
    localparam int NP = 8;
    localparam int W  = DW * NP;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_val = 1'b0;
    logic          in_rdy;
    logic [DW-1:0] input_row [0:NP-1];
    logic          transpose_en = 1'b0;
    logic          out_val;
    logic          out_rdy = 1'b0;
    logic [DW-1:0] output_row [0:NP-1];
    logic          out_last;
    logic          busy;

    mtm_pingpong_unit #(.DATA_WIDTH(DW), .NUM_PE(NP)) dut (
        .clk(clk), .rst(rst), .in_val(in_val), .in_rdy(in_rdy), .input_row(input_row),
        .transpose_en(transpose_en), .out_val(out_val), .out_rdy(out_rdy),
        .output_row(output_row), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int send_m, send_r, n_mats, in_pct, rdy_pct, out_cnt, acc, rdy_drops;
    int t_last_in, t_rise, t_first_out, t_last_out;
    bit toggle_mid = 1'b0;
    bit mat_mode [0:127];
    logic prev_ov = 1'b0;
    logic [DW-1:0] cur [0:NP-1][0:NP-1];
    logic [W-1:0] exp_q [$];

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] elem(int m, int r, int c);
        return (DW'(m) << 16) | (DW'(r) << 4) | DW'(c);
    endfunction

    function automatic logic [W-1:0] out_pk();
        logic [W-1:0] v;
        for (int i = 0; i < NP; i++) v[i*DW +: DW] = output_row[i];
        return v;
    endfunction

    task automatic drive();
        if (!in_val && send_m < n_mats && $urandom_range(99) < in_pct) in_val = 1'b1;
        for (int c = 0; c < NP; c++) input_row[c] = elem(send_m, send_r, c);
        transpose_en = (send_r == 0 || !toggle_mid) ? mat_mode[send_m] : !mat_mode[send_m];
        out_rdy = $urandom_range(99) < rdy_pct;
    endtask

    task automatic cycle();
        logic hs_in, hs_out;
        logic [W-1:0] e;
        hs_in  = in_val && in_rdy;
        hs_out = out_val && out_rdy;
        if (send_m < n_mats && !in_rdy) rdy_drops++;
        if (out_val && !prev_ov && t_rise < 0) t_rise = cyc;
        prev_ov = out_val;
        if (hs_out) begin
            check("sb_avail", W'(exp_q.size() != 0), W'(1));
            e = '0;
            if (exp_q.size() != 0) e = exp_q.pop_front();
            check("row", out_pk(), e);
            check("last", W'(out_last), W'(out_cnt % NP == NP - 1));
            out_cnt++;
            if (t_first_out < 0) t_first_out = cyc;
            t_last_out = cyc;
        end
        if (hs_in) begin
            for (int c = 0; c < NP; c++) cur[send_r][c] = input_row[c];
            acc++;
            if (send_r == NP - 1) begin
                t_last_in = cyc;
                for (int j = 0; j < NP; j++) begin
                    for (int i = 0; i < NP; i++)
                        e[i*DW +: DW] = mat_mode[send_m] ? cur[i][j] : cur[j][i];
                    exp_q.push_back(e);
                end
                send_m++;
                send_r = 0;
            end else begin
                send_r++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (hs_in) in_val = 1'b0;
        drive();
    endtask

    task automatic start(input int n, input int ip, input int rp, input int kind);
        n_mats = n; send_m = 0; send_r = 0; in_pct = ip; rdy_pct = rp;
        acc = 0; rdy_drops = 0; t_rise = -1; t_first_out = -1;
        for (int i = 0; i < n; i++)
            mat_mode[i] = kind == 2 ? 1'($urandom_range(1)) : kind == 3 ? 1'(i % 2) : 1'(kind);
        drive();
    endtask

    task automatic run_done(input int budget);
        int k = 0;
        while ((send_m < n_mats || exp_q.size() != 0 || out_val) && k < budget) begin
            cycle();
            k++;
        end
        check("timeout", W'(k < budget), W'(1));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        for (int c = 0; c < NP; c++) input_row[c] = '0;
        n_mats = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_val", W'(out_val), W'(0));
        check("rst_out_last", W'(out_last), W'(0));
        check("rst_busy", W'(busy), W'(0));
        check("rst_in_rdy", W'(in_rdy), W'(1));
        check("rst_row", out_pk(), W'(0));
        rst = 1'b1;

        start(1, 100, 100, 1);
        run_done(200);
        check("latency", W'(t_rise - t_last_in), W'(2));
        check("rows_t1", W'(out_cnt), W'(8));

        toggle_mid = 1'b1;
        start(1, 100, 100, 0);
        run_done(200);
        toggle_mid = 1'b0;
        check("rows_t2", W'(out_cnt), W'(16));

        start(4, 100, 100, 3);
        run_done(400);
        check("bb_rdy_drops", W'(rdy_drops), W'(0));
        check("bb_contig", W'(t_last_out - t_first_out), W'(31));
        check("rows_t3", W'(out_cnt), W'(48));

        start(3, 100, 0, 3);
        repeat (40) cycle();
        check("stall_acc", W'(acc), W'(16));
        check("stall_in_rdy", W'(in_rdy), W'(0));
        check("stall_out_val", W'(out_val), W'(1));
        check("stall_row0", out_pk(), exp_q[0]);
        rdy_pct = 100;
        run_done(400);
        check("rows_t4", W'(out_cnt), W'(72));

        start(100, 70, 50, 2);
        run_done(20000);
        check("rows_rand", W'(out_cnt), W'(872));

        start(2, 100, 0, 3);
        k = 0;
        while (acc < 13 && k < 100) begin
            cycle();
            k++;
        end
        check("pre_rst_acc", W'(acc), W'(13));
        check("pre_rst_busy", W'(busy), W'(1));
        in_val = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        check("mid_rst_out_val", W'(out_val), W'(0));
        check("mid_rst_busy", W'(busy), W'(0));
        check("mid_rst_in_rdy", W'(in_rdy), W'(1));
        out_cnt = 0;
        prev_ov = out_val;
        start(1, 100, 100, 1);
        run_done(200);
        check("rows_t6", W'(out_cnt), W'(8));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
